// File: rtl/blocpu_dmem_sequencer.sv
// Data-memory sequencer: serialises core 8/16-bit and host byte accesses onto
// one single-port, synchronous-read byte RAM (big-endian for 16-bit beats).
module blocpu_dmem_sequencer #(
  parameter int ADDR_WIDTH    = 16,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  core_req_i,
  input  logic                  core_we_i,
  input  logic                  core_wide_i,
  input  logic [ADDR_WIDTH-1:0] core_addr_i,
  input  logic [15:0]           core_wdata_i,
  output logic                  core_done_o,
  output logic [15:0]           core_rdata_o,
  input  logic                  host_req_i,
  input  logic                  host_we_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [7:0]            host_wdata_i,
  input  logic                  host_hold_i,
  output logic                  host_done_o,
  output logic [7:0]            host_rdata_o,
  output logic                  busy_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [7:0]            mem_wdata_o,
  input  logic [7:0]            mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, C0, C1, CFIN, H0, HFIN} state_t;

  localparam logic [7:0] MAX_WAIT = 8'(HOST_MAX_WAIT);

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic                  wide_q, wide_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [15:0]           core_rdata_q, core_rdata_d;
  logic [7:0]            host_rdata_q, host_rdata_d;
  logic [7:0]            host_wait_q, host_wait_d;
  logic                  host_win, core_win;

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    wide_d       = wide_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    core_rdata_d = core_rdata_q;
    host_rdata_d = host_rdata_q;
    core_done_o  = 1'b0;
    host_done_o  = 1'b0;
    core_rdata_o = core_rdata_q;
    host_rdata_o = host_rdata_q;
    mem_en_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = 8'h00;
    busy_o       = (state_q != IDLE);

    // The host only overtakes a waiting core once it has starved long enough.
    host_win = (state_q == IDLE) && host_req_i &&
               (host_hold_i || (host_wait_q >= MAX_WAIT) || !core_req_i);
    core_win = (state_q == IDLE) && !host_win && core_req_i && !host_hold_i;

    if (host_win || !host_req_i) begin
      host_wait_d = 8'h00;
    end else if (host_wait_q != 8'hFF) begin
      host_wait_d = host_wait_q + 8'h01;
    end else begin
      host_wait_d = host_wait_q;
    end

    case (state_q)
      IDLE: begin
        if (host_win) begin
          state_d = H0;
          we_d    = host_we_i;
          wide_d  = 1'b0;
          addr_d  = host_addr_i;
          wdata_d = {8'h00, host_wdata_i};
        end else if (core_win) begin
          state_d = C0;
          we_d    = core_we_i;
          wide_d  = core_wide_i;
          addr_d  = core_addr_i;
          wdata_d = core_wdata_i;
        end
      end
      C0: begin
        mem_en_o    = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wide_q ? wdata_q[15:8] : wdata_q[7:0];
        state_d     = wide_q ? C1 : CFIN;
      end
      C1: begin
        mem_en_o    = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q + ADDR_WIDTH'(1);
        mem_wdata_o = wdata_q[7:0];
        if (!we_q) begin
          core_rdata_d[15:8] = mem_rdata_i;
        end
        state_d = CFIN;
      end
      CFIN: begin
        core_done_o = 1'b1;
        if (!we_q) begin
          core_rdata_d = wide_q ? {core_rdata_q[15:8], mem_rdata_i} : {8'h00, mem_rdata_i};
        end
        // Present the assembled word during the done cycle itself.
        core_rdata_o = core_rdata_d;
        state_d      = IDLE;
      end
      H0: begin
        mem_en_o    = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q[7:0];
        state_d     = HFIN;
      end
      HFIN: begin
        host_done_o = 1'b1;
        if (!we_q) begin
          host_rdata_d = mem_rdata_i;
        end
        host_rdata_o = host_rdata_d;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      wide_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 16'h0000;
      core_rdata_q <= 16'h0000;
      host_rdata_q <= 8'h00;
      host_wait_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      wide_q       <= wide_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_rdata_q <= core_rdata_d;
      host_rdata_q <= host_rdata_d;
      host_wait_q  <= host_wait_d;
    end
  end

endmodule

// File: tb/tb_blocpu_dmem_sequencer.sv
// Bench for blocpu_dmem_sequencer: directed scenarios plus randomized traffic
// checked cycle by cycle against a transaction-phase reference model.
module tb_blocpu_dmem_sequencer;

  localparam int MAXW = 4;

  logic        clock, reset;
  logic        core_req, core_we, core_wide;
  logic [15:0] core_addr, core_wdata;
  logic        core_done;
  logic [15:0] core_rdata;
  logic        host_req, host_we, host_hold;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_done;
  logic [7:0]  host_rdata;
  logic        busy, mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  blocpu_dmem_sequencer #(.ADDR_WIDTH(16), .HOST_MAX_WAIT(MAXW)) dut (
    .clock(clock), .reset(reset),
    .core_req_i(core_req), .core_we_i(core_we), .core_wide_i(core_wide),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_done_o(core_done), .core_rdata_o(core_rdata),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_hold_i(host_hold),
    .host_done_o(host_done), .host_rdata_o(host_rdata),
    .busy_o(busy), .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  logic [7:0] ram  [0:65535];
  logic [7:0] gold [0:65535];

  int vectors = 0, miscompares = 0;
  int core_done_cnt = 0, host_done_cnt = 0;
  bit core_keep = 0;
  logic [15:0] last_core_rd;
  logic [7:0]  last_host_rd;
  logic        p_en, p_we;
  logic [15:0] p_addr;
  logic [7:0]  p_wd;

  // Reference model: owner (0 none, 1 core, 2 host), phase p of n cycles.
  int          m_owner, m_p, m_n, m_wait;
  bit          m_we, m_wide;
  logic [15:0] m_addr, m_wdata, m_core_rd, m_core_held;
  logic [7:0]  m_host_rd, m_host_held;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_edge();
    bit hw, cw;
    logic [15:0] a1;
    if (reset) begin
      m_owner = 0; m_p = 0; m_n = 0; m_wait = 0;
      m_core_held = 16'h0; m_host_held = 8'h0;
      return;
    end
    hw = (m_owner == 0) && host_req && (host_hold || m_wait >= MAXW || !core_req);
    cw = (m_owner == 0) && !hw && core_req && !host_hold;
    m_wait = (hw || !host_req) ? 0 : ((m_wait < 255) ? m_wait + 1 : 255);
    if (m_owner != 0) begin
      if (m_p < m_n) m_p++;
      else begin
        if (!m_we) begin
          if (m_owner == 1) m_core_held = m_core_rd;
          else m_host_held = m_host_rd;
        end
        m_owner = 0;
      end
    end else if (hw) begin
      m_owner = 2; m_p = 1; m_n = 2; m_we = host_we; m_wide = 0;
      m_addr = host_addr; m_wdata = {8'h00, host_wdata};
      if (host_we) gold[host_addr] = host_wdata;
      else m_host_rd = gold[host_addr];
    end else if (cw) begin
      m_owner = 1; m_p = 1; m_n = core_wide ? 3 : 2; m_we = core_we; m_wide = core_wide;
      m_addr = core_addr; m_wdata = core_wdata;
      a1 = core_addr + 16'd1;
      if (core_we) begin
        if (core_wide) begin
          gold[core_addr] = core_wdata[15:8];
          gold[a1] = core_wdata[7:0];
        end else gold[core_addr] = core_wdata[7:0];
      end else begin
        m_core_rd = core_wide ? {gold[core_addr], gold[a1]} : {8'h00, gold[core_addr]};
      end
    end
  endtask

  task automatic check_cycle();
    logic e_busy, e_en, e_we, e_cd, e_hd;
    logic [15:0] e_addr, e_crd;
    logic [7:0] e_wd, e_hrd;
    e_busy = (m_owner != 0);
    e_en = 0; e_we = 0; e_addr = 16'h0; e_wd = 8'h0;
    e_cd = (m_owner == 1) && (m_p == m_n);
    e_hd = (m_owner == 2) && (m_p == 2);
    if (m_owner == 1 && m_p == 1) begin
      e_en = 1; e_we = m_we; e_addr = m_addr;
      e_wd = m_wide ? m_wdata[15:8] : m_wdata[7:0];
    end else if (m_owner == 1 && m_p == 2 && m_wide) begin
      e_en = 1; e_we = m_we; e_addr = m_addr + 16'd1; e_wd = m_wdata[7:0];
    end else if (m_owner == 2 && m_p == 1) begin
      e_en = 1; e_we = m_we; e_addr = m_addr; e_wd = m_wdata[7:0];
    end
    e_crd = (e_cd && !m_we) ? m_core_rd : m_core_held;
    e_hrd = (e_hd && !m_we) ? m_host_rd : m_host_held;
    chk("bus{busy,en,we,addr,wdata,cdone,hdone}",
        64'({busy, mem_en, mem_we, mem_addr, mem_wdata, core_done, host_done}),
        64'({e_busy, e_en, e_we, e_addr, e_wd, e_cd, e_hd}));
    chk("core_rdata", 64'(core_rdata), 64'(e_crd));
    chk("host_rdata", 64'(host_rdata), 64'(e_hrd));
  endtask

  task automatic sample_mem();
    p_en = mem_en; p_we = mem_we; p_addr = mem_addr; p_wd = mem_wdata;
  endtask

  // One clock: RAM acts on the previous cycle's strobe, then outputs are checked.
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    if (p_en) begin
      if (p_we) ram[p_addr] = p_wd;
      mem_rdata = ram[p_addr];
    end
    #1;
    check_cycle();
    sample_mem();
    if (core_done) begin
      core_done_cnt++; last_core_rd = core_rdata;
      if (!core_keep) core_req = 1'b0;
    end
    if (host_done) begin
      host_done_cnt++; last_host_rd = host_rdata; host_req = 1'b0;
    end
  endtask

  task automatic wait_done(input bit for_core, output int lat, output int steps);
    int k, c0, h0;
    bit prev, seen;
    k = 0; steps = 0; prev = busy; seen = 0; c0 = core_done_cnt; h0 = host_done_cnt;
    while (!seen && steps < 60) begin
      step();
      steps++;
      if (busy && !prev) k = 1;
      else if (busy) k++;
      prev = busy;
      seen = for_core ? (core_done_cnt != c0) : (host_done_cnt != h0);
    end
    lat = k;
    chk(for_core ? "core_done_timeout" : "host_done_timeout", 64'(seen), 64'd1);
  endtask

  initial begin
    int lat, st, c0, h0;
    reset = 1; core_req = 0; core_we = 0; core_wide = 0; core_addr = 0; core_wdata = 0;
    host_req = 0; host_we = 0; host_hold = 0; host_addr = 0; host_wdata = 0;
    mem_rdata = 8'h00; p_en = 0; p_we = 0; p_addr = 0; p_wd = 0;
    m_owner = 0; m_p = 0; m_n = 0; m_wait = 0; m_we = 0; m_wide = 0;
    m_addr = 0; m_wdata = 0; m_core_rd = 0; m_core_held = 0; m_host_rd = 0; m_host_held = 0;
    last_core_rd = 0; last_host_rd = 0;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 8'(i * 7 + 3);
      gold[i] = ram[i];
    end
    ram[16'h1234] = 8'hAB; gold[16'h1234] = 8'hAB;
    ram[16'h0040] = 8'h5A; gold[16'h0040] = 8'h5A;
    ram[16'h0041] = 8'h77; gold[16'h0041] = 8'h77;
    ram[16'h0010] = 8'hC3; gold[16'h0010] = 8'hC3;
    #1;
    chk("reset_outputs", 64'({busy, mem_en, mem_we, mem_addr, mem_wdata, core_done,
        host_done, core_rdata, host_rdata}), 64'd0);
    step(); step();
    reset = 0;
    step();

    // Narrow read.
    core_req = 1; core_we = 0; core_wide = 0; core_addr = 16'h1234;
    wait_done(1, lat, st);
    chk("narrow_read_latency", 64'(lat), 64'd2);
    chk("narrow_read_data", 64'(last_core_rd), 64'h00AB);

    // Wide write across the address wrap, then read back.
    core_req = 1; core_we = 1; core_wide = 1; core_addr = 16'hFFFF; core_wdata = 16'hBEEF;
    wait_done(1, lat, st);
    chk("wide_write_latency", 64'(lat), 64'd3);
    chk("wrap_byte_hi", 64'(ram[16'hFFFF]), 64'hBE);
    chk("wrap_byte_lo", 64'(ram[16'h0000]), 64'hEF);
    core_req = 1; core_we = 0; core_wide = 1; core_addr = 16'hFFFF;
    wait_done(1, lat, st);
    chk("wide_read_latency", 64'(lat), 64'd3);
    chk("wide_read_data", 64'(last_core_rd), 64'hBEEF);

    // Simultaneous requests with no accumulated wait: core first.
    step();
    h0 = host_done_cnt;
    core_req = 1; core_we = 0; core_wide = 0; core_addr = 16'h0300;
    host_req = 1; host_we = 0; host_addr = 16'h0040;
    wait_done(1, lat, st);
    chk("core_before_host", 64'(host_done_cnt - h0), 64'd0);
    wait_done(0, lat, st);
    chk("host_latency", 64'(lat), 64'd2);
    chk("host_read_data", 64'(last_host_rd), 64'h5A);

    // Continuous core traffic: host wins once its wait reaches the limit.
    step();
    core_keep = 1; core_req = 1; core_we = 0; core_wide = 0; core_addr = 16'h0100;
    host_req = 1; host_we = 0; host_addr = 16'h0041;
    c0 = core_done_cnt; h0 = host_done_cnt;
    for (int i = 0; i < 60 && host_done_cnt == h0; i++) step();
    chk("starved_host_served", 64'(host_done_cnt - h0), 64'd1);
    chk("core_txns_before_host", 64'(core_done_cnt - c0), 64'd2);
    chk("starved_host_data", 64'(last_host_rd), 64'h77);
    core_keep = 0;
    wait_done(1, lat, st);
    chk("core_resume_latency", 64'(lat), 64'd2);

    // host_hold blocks the core; host still served; release grants core.
    host_hold = 1; core_req = 1; core_we = 0; core_wide = 0; core_addr = 16'h0200;
    c0 = core_done_cnt;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_blocks_core", 64'(busy), 64'd0);
    end
    host_req = 1; host_we = 0; host_addr = 16'h0010;
    wait_done(0, lat, st);
    chk("hold_host_data", 64'(last_host_rd), 64'hC3);
    chk("hold_no_core_done", 64'(core_done_cnt - c0), 64'd0);
    host_hold = 0;
    wait_done(1, lat, st);
    chk("hold_release_steps", 64'(st), 64'd3);
    chk("hold_release_latency", 64'(lat), 64'd2);

    // Reset during the second beat of a wide write.
    step();
    ram[16'h2000] = 8'h00; gold[16'h2000] = 8'h00;
    ram[16'h2001] = 8'h11; gold[16'h2001] = 8'h11;
    core_req = 1; core_we = 1; core_wide = 1; core_addr = 16'h2000; core_wdata = 16'h1357;
    step(); step();
    reset = 1; core_req = 0;
    #1;
    chk("reset_mid_c1", 64'({busy, mem_en, mem_we, mem_addr, mem_wdata, core_done,
        host_done, core_rdata, host_rdata}), 64'd0);
    sample_mem();
    gold[16'h2001] = 8'h11;
    step(); step();
    reset = 0;
    step();
    chk("partial_byte0", 64'(ram[16'h2000]), 64'h13);
    chk("partial_byte1", 64'(ram[16'h2001]), 64'h11);

    // Randomized mixed traffic around the wrap boundary.
    for (int i = 0; i < 600; i++) begin
      if (!core_req && $urandom_range(0, 2) == 0) begin
        core_req = 1; core_we = 1'($urandom_range(0, 1)); core_wide = 1'($urandom_range(0, 1));
        core_addr = 16'hFFF8 + 16'($urandom_range(0, 15)); core_wdata = 16'($urandom);
      end
      if (!host_req && $urandom_range(0, 3) == 0) begin
        host_req = 1; host_we = 1'($urandom_range(0, 1));
        host_addr = 16'hFFF8 + 16'($urandom_range(0, 15)); host_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 31) == 0) host_hold = !host_hold;
      step();
    end
    host_hold = 0;
    for (int i = 0; i < 100 && (core_req || host_req); i++) step();
    chk("drain_complete", 64'({core_req, host_req}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
